// File: rtl/dadda_mult_pipe_if.sv
// Operand/result handshake bundle for dadda_mult_pipe.
// The source side drives operands and out_ready; the multiplier drives the rest.
interface dadda_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output in_valid, in1, in2, signed_mode, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, in1, in2, signed_mode, out_ready,
    output in_ready, out_valid, prod
  );
endinterface

// File: rtl/dadda_mult_pipe.sv
// Pipelined, width-generic Dadda-tree multiplier with Baugh-Wooley signed support
// and a single global stall (advance) shared by every pipeline stage.
module dadda_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  dadda_mult_pipe_if.slave   bus
);

  localparam int PW   = 2 * WIDTH;
  localparam int NCOL = PW + 1;

  logic          advance;
  logic          accept;
  logic          out_valid_reg;
  logic [PW-1:0] prod_reg;
  logic [PW-1:0] row0;
  logic [PW-1:0] row1;

  assign advance       = !out_valid_reg || bus.out_ready;
  assign accept        = bus.in_valid && advance;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_reg;
  assign bus.prod      = prod_reg;

  function automatic int dseq(input int idx);
    case (idx)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      4:       return 9;
      5:       return 13;
      6:       return 19;
      default: return 28;
    endcase
  endfunction

  // Bits are kept per column as a stack; heights are elaboration-time constants after unrolling.
  always_comb begin : dadda_tree
    logic [WIDTH-1:0] m  [NCOL];
    logic [WIDTH-1:0] n  [NCOL];
    int               h  [NCOL];
    int               nh [NCOL];
    int               e;
    int               fa;
    int               ha;
    int               k;
    int               d;
    logic             x;
    logic             y;
    logic             z;
    m    = '{default: '0};
    n    = '{default: '0};
    h    = '{default: 0};
    nh   = '{default: 0};
    e    = 0;
    fa   = 0;
    ha   = 0;
    k    = 0;
    d    = 0;
    x    = 1'b0;
    y    = 1'b0;
    z    = 1'b0;
    row0 = '0;
    row1 = '0;

    // Baugh-Wooley: terms with exactly one sign bit are inverted in signed mode.
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        m[i+j][h[i+j]] = (bus.in1[i] & bus.in2[j]) ^
                         (bus.signed_mode & ((i == WIDTH-1) != (j == WIDTH-1)));
        h[i+j] = h[i+j] + 1;
      end
    end
    m[WIDTH][h[WIDTH]] = bus.signed_mode;
    h[WIDTH]           = h[WIDTH] + 1;
    m[PW-1][h[PW-1]]   = bus.signed_mode;
    h[PW-1]            = h[PW-1] + 1;

    for (int s = 7; s >= 0; s--) begin
      d = dseq(s);
      if (d < WIDTH) begin
        n  = '{default: '0};
        nh = '{default: 0};
        for (int c = 0; c < PW; c++) begin
          // nh[c] already holds carries pushed in from column c-1 during this stage.
          e  = h[c] + nh[c] - d;
          fa = (e > 0) ? e / 2 : 0;
          ha = (e > 0) ? e % 2 : 0;
          k  = 0;
          for (int f = 0; f < WIDTH; f++) begin
            if (f < fa) begin
              x = m[c][k];
              y = m[c][k+1];
              z = m[c][k+2];
              n[c][nh[c]]     = x ^ y ^ z;
              nh[c]           = nh[c] + 1;
              n[c+1][nh[c+1]] = (x & y) | (x & z) | (y & z);
              nh[c+1]         = nh[c+1] + 1;
              k               = k + 3;
            end
          end
          if (ha == 1) begin
            x = m[c][k];
            y = m[c][k+1];
            n[c][nh[c]]     = x ^ y;
            nh[c]           = nh[c] + 1;
            n[c+1][nh[c+1]] = x & y;
            nh[c+1]         = nh[c+1] + 1;
            k               = k + 2;
          end
          for (int f = 0; f < WIDTH; f++) begin
            if (f >= k && f < h[c]) begin
              n[c][nh[c]] = m[c][f];
              nh[c]       = nh[c] + 1;
            end
          end
        end
        m = n;
        h = nh;
      end
    end

    for (int c = 0; c < PW; c++) begin
      row0[c] = m[c][0];
      row1[c] = m[c][1];
    end
  end

  generate
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("dadda_mult_pipe: WIDTH must be in 4..32");
    end

    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_reg <= 1'b0;
          prod_reg      <= '0;
        end else if (advance) begin
          out_valid_reg <= accept;
          prod_reg      <= row0 + row1;
        end
      end
    end else if (STAGES == 2) begin : g_two
      logic          s1_valid_reg;
      logic [PW-1:0] s1_row0_reg;
      logic [PW-1:0] s1_row1_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_reg  <= 1'b0;
          s1_row0_reg   <= '0;
          s1_row1_reg   <= '0;
          out_valid_reg <= 1'b0;
          prod_reg      <= '0;
        end else if (advance) begin
          s1_valid_reg  <= accept;
          s1_row0_reg   <= row0;
          s1_row1_reg   <= row1;
          out_valid_reg <= s1_valid_reg;
          prod_reg      <= s1_row0_reg + s1_row1_reg;
        end
      end
    end else begin : g_bad_stages
      $error("dadda_mult_pipe: STAGES must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Self-checking bench for dadda_mult_pipe: directed vector table, backpressure and
// reset sequences, then randomised traffic scored against an arithmetic reference.
module tb_dadda_mult_pipe;

  logic clk;
  logic rst_n;

  dadda_mult_pipe_if #(.WIDTH(8))  i8 ();
  dadda_mult_pipe_if #(.WIDTH(16)) i16 ();
  dadda_mult_pipe_if #(.WIDTH(13)) i13 ();

  dadda_mult_pipe #(.WIDTH(8),  .STAGES(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  dadda_mult_pipe #(.WIDTH(16), .STAGES(1)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
  dadda_mult_pipe #(.WIDTH(13), .STAGES(2)) u13 (.clk(clk), .rst_n(rst_n), .bus(i13.slave));

  // Shared drive/monitor bus; sel picks which instance is under test.
  int          sel;
  logic        drv_valid;
  logic [31:0] drv_a;
  logic [31:0] drv_b;
  logic        drv_sm;
  logic        drv_oready;
  logic        mon_in_ready;
  logic        mon_out_valid;
  logic [63:0] mon_prod;

  assign i8.in_valid     = (sel == 0) && drv_valid;
  assign i8.in1          = drv_a[7:0];
  assign i8.in2          = drv_b[7:0];
  assign i8.signed_mode  = drv_sm;
  assign i8.out_ready    = (sel == 0) ? drv_oready : 1'b1;
  assign i16.in_valid    = (sel == 1) && drv_valid;
  assign i16.in1         = drv_a[15:0];
  assign i16.in2         = drv_b[15:0];
  assign i16.signed_mode = drv_sm;
  assign i16.out_ready   = (sel == 1) ? drv_oready : 1'b1;
  assign i13.in_valid    = (sel == 2) && drv_valid;
  assign i13.in1         = drv_a[12:0];
  assign i13.in2         = drv_b[12:0];
  assign i13.signed_mode = drv_sm;
  assign i13.out_ready   = (sel == 2) ? drv_oready : 1'b1;

  always_comb begin
    mon_in_ready  = i13.in_ready;
    mon_out_valid = i13.out_valid;
    mon_prod      = 64'(i13.prod);
    if (sel == 0) begin
      mon_in_ready  = i8.in_ready;
      mon_out_valid = i8.out_valid;
      mon_prod      = 64'(i8.prod);
    end else if (sel == 1) begin
      mon_in_ready  = i16.in_ready;
      mon_out_valid = i16.out_valid;
      mon_prod      = 64'(i16.prod);
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    bit          sm;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          stamp;
  } sb_t;

  sb_t         exp_q[$];
  vec_t        vecs[17];
  int          n_cmp;
  int          n_err;
  int          cyc;
  bit          chk_lat;
  bit          last_acc;
  bit          prev_hold;
  logic [63:0] prev_prod;

  function automatic int cur_stages();
    return (sel == 1) ? 1 : 2;
  endfunction

  function automatic int cur_width();
    return (sel == 0) ? 8 : ((sel == 1) ? 16 : 13);
  endfunction

  // Reference: plain integer multiply, operands sign-extended when signed, reduced mod 2^(2w).
  function automatic logic [63:0] ref_prod(input int w, input logic [63:0] a,
                                           input logic [63:0] b, input bit sm);
    longint      sa;
    longint      sb;
    logic [63:0] mask;
    mask = (64'd1 << (2 * w)) - 64'd1;
    if (sm) begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      return 64'(sa * sb) & mask;
    end
    return (a * b) & mask;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d, dut %0d)", name, act, req, cyc, sel);
    end
  endtask

  // One clock: sample at negedge, score transfers, then step past the rising edge.
  task automatic tick(input logic [63:0] exp_push);
    sb_t ent;
    @(negedge clk);
    cyc++;
    last_acc = drv_valid && mon_in_ready;
    cmp("in_ready_rule", 64'(mon_in_ready), 64'(!mon_out_valid || drv_oready));
    if (prev_hold) begin
      cmp("hold_valid", 64'(mon_out_valid), 64'd1);
      cmp("hold_prod", mon_prod, prev_prod);
    end
    if (mon_out_valid && drv_oready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_out: got prod 0x%0h, want no output (cycle %0d)", mon_prod, cyc);
      end else begin
        ent = exp_q.pop_front();
        cmp("prod", mon_prod, ent.exp);
        if (chk_lat) cmp("latency", 64'(cyc - ent.stamp), 64'(cur_stages()));
      end
    end
    if (last_acc) begin
      ent.exp   = exp_push;
      ent.stamp = cyc;
      exp_q.push_back(ent);
      cmp("occupancy_ok", 64'(exp_q.size() <= cur_stages()), 64'd1);
    end
    prev_hold = mon_out_valid && !drv_oready;
    prev_prod = mon_prod;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit sm,
                      input logic [63:0] e);
    drv_a     = a;
    drv_b     = b;
    drv_sm    = sm;
    drv_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      tick(e);
      if (last_acc) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got no accept in 100 cycles, want accept (a=0x%0h b=0x%0h)", a, b);
  endtask

  task automatic drain();
    drv_valid  = 1'b0;
    drv_oready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0) break;
      tick(64'd0);
    end
    cmp("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_random(input int s, input int n);
    int          acc_n;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] mask;
    bit          sm;
    acc_n   = 0;
    sel     = s;
    chk_lat = 1'b0;
    mask    = (64'd1 << cur_width()) - 64'd1;
    for (int t = 0; t < 40 * n && acc_n < n; t++) begin
      a          = 64'($urandom) & mask;
      b          = 64'($urandom) & mask;
      sm         = 1'($urandom_range(1));
      drv_a      = a[31:0];
      drv_b      = b[31:0];
      drv_sm     = sm;
      drv_valid  = ($urandom_range(3) != 0);
      drv_oready = ($urandom_range(9) < 7);
      tick(ref_prod(cur_width(), a, b, sm));
      if (last_acc) acc_n++;
    end
    cmp("rand_accepts", 64'(acc_n), 64'(n));
    drain();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    cyc        = 0;
    chk_lat    = 1'b0;
    prev_hold  = 1'b0;
    prev_prod  = '0;
    last_acc   = 1'b0;
    rst_n      = 1'b0;
    drv_valid  = 1'b0;
    drv_a      = '0;
    drv_b      = '0;
    drv_sm     = 1'b0;
    drv_oready = 1'b1;
    sel        = 0;

    vecs[0]  = '{0, 32'd1,      32'd2,      1'b0, 64'd2};
    vecs[1]  = '{0, 32'd128,    32'd64,     1'b0, 64'h2000};
    vecs[2]  = '{0, 32'd200,    32'd38,     1'b0, 64'd7600};
    vecs[3]  = '{0, 32'd255,    32'd255,    1'b0, 64'd65025};
    vecs[4]  = '{0, 32'hFF,     32'hFF,     1'b1, 64'h0001};
    vecs[5]  = '{0, 32'h80,     32'h7F,     1'b1, 64'hC080};
    vecs[6]  = '{0, 32'h80,     32'h80,     1'b1, 64'h4000};
    vecs[7]  = '{0, 32'h05,     32'hFD,     1'b1, 64'hFFF1};
    vecs[8]  = '{0, 32'hFF,     32'hFF,     1'b0, 64'hFE01};
    vecs[9]  = '{0, 32'h00,     32'h5A,     1'b1, 64'h0};
    vecs[10] = '{0, 32'hFF,     32'h00,     1'b0, 64'h0};
    vecs[11] = '{1, 32'hFFFF,   32'hFFFF,   1'b0, 64'hFFFE0001};
    vecs[12] = '{1, 32'h8000,   32'h8000,   1'b1, 64'h40000000};
    vecs[13] = '{1, 32'h8000,   32'h7FFF,   1'b1, 64'hC0008000};
    vecs[14] = '{1, 32'h0000,   32'hFFFF,   1'b1, 64'h0};
    vecs[15] = '{2, 32'h1FFF,   32'h1FFF,   1'b0, 64'h3FFC001};
    vecs[16] = '{2, 32'h1000,   32'h1000,   1'b1, 64'h1000000};

    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      cmp("rst_out_valid", 64'(mon_out_valid), 64'd0);
      cmp("rst_prod", mon_prod, 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      cmp("rel_in_ready", 64'(mon_in_ready), 64'd1);
    end
    sel = 0;

    // Directed vectors, streamed back-to-back per instance with latency checked.
    chk_lat = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].sel != sel) begin
        drain();
        sel = vecs[i].sel;
      end
      send(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);
    end
    drain();
    $display("directed vectors: %0d compared, %0d mismatched so far", n_cmp, n_err);

    // Backpressure: two fill the pipe, the third waits until the consumer frees a slot.
    sel        = 0;
    chk_lat    = 1'b0;
    drv_oready = 1'b0;
    send(32'd3, 32'd4, 1'b0, 64'd12);
    send(32'd5, 32'd6, 1'b0, 64'd30);
    drv_a     = 32'd7;
    drv_b     = 32'd8;
    drv_sm    = 1'b0;
    drv_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick(64'd56);
      cmp("bp_no_accept", 64'(last_acc), 64'd0);
      cmp("bp_prod", mon_prod, 64'd12);
    end
    drv_oready = 1'b1;
    send(32'd7, 32'd8, 1'b0, 64'd56);
    drain();
    $display("backpressure: %0d compared, %0d mismatched so far", n_cmp, n_err);

    // Reset mid-flight: 6 waits at the output, 81 sits in stage 1; both must vanish.
    drv_oready = 1'b0;
    send(32'd2, 32'd3, 1'b0, 64'd6);
    send(32'd9, 32'd9, 1'b0, 64'd81);
    drv_valid = 1'b0;
    cmp("pre_rst_valid", 64'(mon_out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_valid", 64'(mon_out_valid), 64'd0);
    cmp("async_rst_prod", mon_prod, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    prev_hold  = 1'b0;
    drv_oready = 1'b1;
    cmp("post_rst_in_ready", 64'(mon_in_ready), 64'd1);
    for (int t = 0; t < 6; t++) tick(64'd0);
    cmp("post_rst_quiet", 64'(mon_out_valid), 64'd0);
    $display("reset flush: %0d compared, %0d mismatched so far", n_cmp, n_err);

    run_random(0, 2000);
    $display("random W=8: %0d compared, %0d mismatched so far", n_cmp, n_err);
    run_random(2, 2000);
    $display("random W=13: %0d compared, %0d mismatched so far", n_cmp, n_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
